// File: rtl/prob_fusion_n.sv
// N-channel probability fusion: per-sample noisy-OR / product / max fold over
// clamped channels, followed by threshold detection and a saturating hit counter.
module prob_fusion_n #(
    parameter int W      = 16,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [NUM_CH*W-1:0] prob_in,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic [1:0]          mode,
    input  logic [W-1:0]        threshold,
    output logic                valid_out,
    output logic [W-1:0]        prob_out,
    output logic                detect,
    output logic [CNT_W-1:0]    det_count
);

    // Slot 0 is the input register; fold stage k uses slots 2k-1 (cycle A) and 2k (cycle B).
    localparam int NS = 2*NUM_CH - 1;
    localparam logic [W-1:0] ONE = {1'b1, {(W-1){1'b0}}};
    localparam logic [1:0] MODE_OR  = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;

    logic [1:0]   mode_n;
    logic [W-1:0] in_ch   [NUM_CH];
    logic [W-1:0] vec_reg [NS][NUM_CH];
    logic [1:0]   mode_reg [NS];
    logic [W-1:0] thr_reg  [NS];
    logic [NS-1:0] vld_reg;
    logic [W-1:0] p_reg  [1:NUM_CH-1];
    logic [W-1:0] p_next [1:NUM_CH-1];
    logic [W-1:0] f_next [1:NUM_CH-1];

    assign mode_n = (mode == 2'd3) ? MODE_OR : mode;

    // Clamp to ONE, and substitute the mode's identity for disabled channels.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_in
            logic [W-1:0] raw;
            assign raw       = prob_in[gi*W +: W];
            assign in_ch[gi] = !ch_en[gi] ? ((mode_n == MODE_AND) ? ONE : '0)
                                          : ((raw > ONE) ? ONE : raw);
        end
    endgenerate

    generate
        for (genvar gi = 1; gi < NUM_CH; gi++) begin : g_fold
            localparam int SA = 2*gi - 1;
            logic [2*W-1:0] prod;
            logic [W:0]     or_sum;
            logic [W-1:0]   acc_a;
            logic [W-1:0]   ch_a;

            assign prod       = {{W{1'b0}}, vec_reg[SA-1][0]} * {{W{1'b0}}, vec_reg[SA-1][gi]};
            assign p_next[gi] = W'(prod >> (W-1));

            assign acc_a  = vec_reg[SA][0];
            assign ch_a   = vec_reg[SA][gi];
            // p never exceeds min(acc, ch), so the subtraction cannot underflow.
            assign or_sum = {1'b0, acc_a} + {1'b0, ch_a} - {1'b0, p_reg[gi]};
            assign f_next[gi] =
                (mode_reg[SA] == MODE_AND) ? p_reg[gi] :
                (mode_reg[SA] == MODE_MAX) ? ((acc_a >= ch_a) ? acc_a : ch_a) :
                ((or_sum > {1'b0, ONE}) ? ONE : or_sum[W-1:0]);
        end
    endgenerate

    // Data path: no reset needed, validity is tracked separately in vld_reg.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            vec_reg[0][c] <= in_ch[c];
        end
        mode_reg[0] <= mode_n;
        thr_reg[0]  <= threshold;
        for (int s = 1; s < NS; s++) begin
            mode_reg[s] <= mode_reg[s-1];
            thr_reg[s]  <= thr_reg[s-1];
            for (int c = 0; c < NUM_CH; c++) begin
                vec_reg[s][c] <= vec_reg[s-1][c];
            end
        end
        for (int k = 1; k < NUM_CH; k++) begin
            p_reg[k]        <= p_next[k];
            vec_reg[2*k][0] <= f_next[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg   <= '0;
            valid_out <= 1'b0;
            prob_out  <= '0;
            detect    <= 1'b0;
            det_count <= '0;
        end else begin
            vld_reg   <= {vld_reg[NS-2:0], valid_in};
            valid_out <= vld_reg[NS-1];
            if (vld_reg[NS-1]) begin
                prob_out <= vec_reg[NS-1][0];
                detect   <= (vec_reg[NS-1][0] >= thr_reg[NS-1]);
            end
            if (valid_out && detect && (det_count != {CNT_W{1'b1}})) begin
                det_count <= det_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prob_fusion_n.sv
// Bench for prob_fusion_n: a 2-channel instance (4-bit counter) and a 3-channel
// instance, both checked against a queued reference of expected outputs.
module tb_prob_fusion_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic        a_valid = 1'b0;
    logic [31:0] a_prob  = '0;
    logic [1:0]  a_en    = '0;
    logic [1:0]  a_mode  = '0;
    logic [15:0] a_thr   = '0;
    logic        a_vo;
    logic [15:0] a_po;
    logic        a_det;
    logic [3:0]  a_cnt;

    logic        b_valid = 1'b0;
    logic [47:0] b_prob  = '0;
    logic [2:0]  b_en    = '0;
    logic [1:0]  b_mode  = '0;
    logic [15:0] b_thr   = '0;
    logic        b_vo;
    logic [15:0] b_po;
    logic        b_det;
    logic [15:0] b_cnt;

    typedef struct packed {
        logic [15:0] p;
        logic        d;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int n_cmp = 0;
    int n_bad = 0;

    prob_fusion_n #(.W(16), .NUM_CH(2), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .valid_in(a_valid), .prob_in(a_prob), .ch_en(a_en),
        .mode(a_mode), .threshold(a_thr), .valid_out(a_vo), .prob_out(a_po),
        .detect(a_det), .det_count(a_cnt)
    );

    prob_fusion_n #(.W(16), .NUM_CH(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .valid_in(b_valid), .prob_in(b_prob), .ch_en(b_en),
        .mode(b_mode), .threshold(b_thr), .valid_out(b_vo), .prob_out(b_po),
        .detect(b_det), .det_count(b_cnt)
    );

    // Reference fold on plain integers, 1.0 = 32768.
    function automatic logic [15:0] fuse(input int n, input logic [47:0] chv,
                                         input logic [2:0] en, input logic [1:0] md);
        int m, acc, v, p;
        int vals[3];
        m = (md == 2'd3) ? 0 : int'(md);
        for (int k = 0; k < n; k++) begin
            v = int'(chv[k*16 +: 16]);
            if (v > 32768) v = 32768;
            if (!en[k]) v = (m == 1) ? 32768 : 0;
            vals[k] = v;
        end
        acc = vals[0];
        for (int k = 1; k < n; k++) begin
            p = (acc * vals[k]) / 32768;
            case (m)
                0: begin
                    acc = acc + vals[k] - p;
                    if (acc > 32768) acc = 32768;
                end
                1: acc = p;
                default: if (vals[k] > acc) acc = vals[k];
            endcase
        end
        return 16'(acc);
    endfunction

    // Scoreboard: every valid_out pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_vo === 1'b1) begin
                n_cmp++;
                if (q_a.size() == 0) begin
                    n_bad++;
                    $display("FAIL a_unexpected: valid_out with prob_out=%h, none expected", a_po);
                end else begin
                    e = q_a.pop_front();
                    if ({a_po, a_det} !== {e.p, e.d}) begin
                        n_bad++;
                        $display("FAIL a_output: got prob=%h det=%b, expected prob=%h det=%b", a_po, a_det, e.p, e.d);
                    end
                end
            end
            if (b_vo === 1'b1) begin
                n_cmp++;
                if (q_b.size() == 0) begin
                    n_bad++;
                    $display("FAIL b_unexpected: valid_out with prob_out=%h, none expected", b_po);
                end else begin
                    e = q_b.pop_front();
                    if ({b_po, b_det} !== {e.p, e.d}) begin
                        n_bad++;
                        $display("FAIL b_output: got prob=%h det=%b, expected prob=%h det=%b", b_po, b_det, e.p, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_a(input logic [15:0] c0, input logic [15:0] c1, input logic [1:0] en,
                          input logic [1:0] md, input logic [15:0] thr, input logic [15:0] ep);
        exp_t e;
        cyc();
        a_valid = 1'b1; a_prob = {c1, c0}; a_en = en; a_mode = md; a_thr = thr;
        e.p = ep; e.d = (ep >= thr);
        if (!rst) q_a.push_back(e);
        $display("a in: %h %h en=%b mode=%0d thr=%h expect %h", c0, c1, en, md, thr, ep);
    endtask

    task automatic send_b(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                          input logic [2:0] en, input logic [1:0] md, input logic [15:0] thr,
                          input logic [15:0] ep);
        exp_t e;
        cyc();
        b_valid = 1'b1; b_prob = {c2, c1, c0}; b_en = en; b_mode = md; b_thr = thr;
        e.p = ep; e.d = (ep >= thr);
        if (!rst) q_b.push_back(e);
        $display("b in: %h %h %h en=%b mode=%0d thr=%h expect %h", c0, c1, c2, en, md, thr, ep);
    endtask

    task automatic drain();
        int t = 0;
        cyc();
        while ((q_a.size() > 0 || q_b.size() > 0) && t < 60) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic apply_reset();
        cyc();
        rst = 1'b1;
        cyc();
        q_a.delete();
        q_b.delete();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        @(negedge clk);
        n_cmp++;
        if ({a_vo, a_po, a_det, a_cnt} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_a: got vo=%b po=%h det=%b cnt=%h, required all 0", a_vo, a_po, a_det, a_cnt);
        end
        n_cmp++;
        if ({b_vo, b_po, b_det, b_cnt} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_b: got vo=%b po=%h det=%b cnt=%h, required all 0", b_vo, b_po, b_det, b_cnt);
        end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_or_latency();
        int lat;
        send_a(16'h4000, 16'h4000, 2'b11, 2'd0, 16'h6000, 16'h6000);
        cyc();
        lat = 1;
        forever begin
            @(negedge clk);
            if (a_vo === 1'b1 || lat > 20) break;
            lat++;
        end
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL latency_a: got %0d cycles, required 4", lat);
        end
        n_cmp++;
        if (a_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL cnt_early: got %0d with valid_out, required 0", a_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (a_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL cnt_after: got %0d, required 1", a_cnt);
        end
    endtask

    task automatic test_mode_tag();
        send_a(16'h4000, 16'h4000, 2'b11, 2'd1, 16'h6000, 16'h2000);
        send_a(16'h4000, 16'h4000, 2'b11, 2'd2, 16'h6000, 16'h4000);
        drain();
    endtask

    task automatic test_three_ch();
        int lat;
        send_b(16'h4000, 16'h4000, 16'h4000, 3'b111, 2'd0, 16'h7000, 16'h7000);
        cyc();
        lat = 1;
        forever begin
            @(negedge clk);
            if (b_vo === 1'b1 || lat > 20) break;
            lat++;
        end
        n_cmp++;
        if (lat !== 6) begin
            n_bad++;
            $display("FAIL latency_b: got %0d cycles, required 6", lat);
        end
        send_b(16'h4000, 16'h4000, 16'h4000, 3'b011, 2'd0, 16'h7000, 16'h6000);
        send_b(16'h4000, 16'h4000, 16'h4000, 3'b101, 2'd1, 16'h1000, 16'h2000);
        drain();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (b_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL cnt_b: got %0d, required 2", b_cnt);
        end
    endtask

    task automatic test_clamp();
        send_a(16'hFFFF, 16'h8000, 2'b11, 2'd0, 16'h8000, 16'h8000);
        send_a(16'hFFFF, 16'h4000, 2'b11, 2'd1, 16'h4001, 16'h4000);
        send_a(16'h4000, 16'h4000, 2'b11, 2'd3, 16'h0000, 16'h6000);
        send_a(16'h4000, 16'h1234, 2'b01, 2'd1, 16'h0000, 16'h4000);
        send_a(16'h3000, 16'h5000, 2'b11, 2'd2, 16'h5000, 16'h5000);
        send_a(16'h3000, 16'h5000, 2'b11, 2'd2, 16'h5001, 16'h5000);
        send_a(16'h4000, 16'h4000, 2'b00, 2'd0, 16'h0000, 16'h0000);
        drain();
    endtask

    task automatic test_stream();
        logic [15:0] c0, c1, thr, ep;
        logic [1:0]  en, md;
        int ndet, ghosts;
        apply_reset();
        ndet = 0;
        for (int i = 0; i < 20; i++) begin
            idle($urandom_range(0, 2));
            c0  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'hFFFF)) : 16'($urandom_range(0, 16'h8000));
            c1  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'hFFFF)) : 16'($urandom_range(0, 16'h8000));
            en  = 2'($urandom_range(0, 3));
            md  = 2'($urandom_range(0, 3));
            thr = 16'($urandom_range(0, 16'h8000));
            ep  = fuse(2, {16'h0000, c1, c0}, {1'b1, en}, md);
            if (ep >= thr) ndet++;
            send_a(c0, c1, en, md, thr, ep);
        end
        drain();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (int'(a_cnt) !== ((ndet > 15) ? 15 : ndet)) begin
            n_bad++;
            $display("FAIL cnt_stream: got %0d, required %0d", a_cnt, (ndet > 15) ? 15 : ndet);
        end
        // Three samples in flight, then reset together with a fourth vector.
        send_a(16'h4000, 16'h4000, 2'b11, 2'd0, 16'h0000, 16'h6000);
        send_a(16'h2000, 16'h4000, 2'b11, 2'd2, 16'h0000, 16'h4000);
        send_a(16'h8000, 16'h8000, 2'b11, 2'd1, 16'h0000, 16'h8000);
        cyc();
        rst = 1'b1;
        a_valid = 1'b1; a_prob = {16'h7000, 16'h7000}; a_en = 2'b11; a_mode = 2'd0; a_thr = 16'h0000;
        cyc();
        q_a.delete();
        q_b.delete();
        idle(2);
        @(negedge clk);
        n_cmp++;
        if ({a_vo, a_po, a_det, a_cnt} !== 22'd0) begin
            n_bad++;
            $display("FAIL midreset_a: got vo=%b po=%h det=%b cnt=%h, required all 0", a_vo, a_po, a_det, a_cnt);
        end
        cyc();
        rst = 1'b0;
        ghosts = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_vo === 1'b1) ghosts++;
        end
        n_cmp++;
        if (ghosts !== 0) begin
            n_bad++;
            $display("FAIL flushed: got %0d outputs after reset, required 0", ghosts);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            send_a(16'h4000, 16'h4000, 2'b11, 2'd0, 16'h0000, 16'h6000);
        end
        drain();
        idle(3);
        @(negedge clk);
        n_cmp++;
        if (a_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL cnt_sat: got %0d, required 15", a_cnt);
        end
        send_a(16'h4000, 16'h4000, 2'b11, 2'd0, 16'h0000, 16'h6000);
        drain();
        idle(3);
        @(negedge clk);
        n_cmp++;
        if (a_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL cnt_hold: got %0d, required 15", a_cnt);
        end
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if (a_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL cnt_clear: got %0d, required 0", a_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_or_latency();
        test_mode_tag();
        test_three_ch();
        test_clamp();
        test_stream();
        test_saturate();
        idle(4);
        n_cmp++;
        if (q_a.size() + q_b.size() != 0) begin
            n_bad++;
            $display("FAIL pending: %0d expected outputs never seen, required 0", q_a.size() + q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
